// File: rtl/gth_sample_framer.sv
// gth_sample_framer: packs 3-channel comparator samples into 80-bit GTH TX words,
// with an alignment preamble, sequence-numbered data frames, sweep markers and idle fill.
module gth_sample_framer #(
  parameter int SAMPLES_PER_FRAME = 19,
  parameter int ALIGN_CYCLES      = 256
) (
  input  logic        ref_clk,
  input  logic        ref_rst_n,
  input  logic        enable,
  input  logic        realign,
  input  logic        sweep_start,
  input  logic        sample_valid,
  input  logic        cmp_ref,
  input  logic        cmp_s11,
  input  logic        cmp_s21,
  output logic [79:0] GTH_DATA,
  output logic        frame_valid,
  output logic        align_done,
  output logic        triger
);
  localparam logic [79:0] ALIGN_WORD = {8'hBC, 72'h0};
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_CYCLES - 1);
  localparam logic [4:0]  FULL_COUNT = 5'(SAMPLES_PER_FRAME);

  typedef enum logic {ST_ALIGN, ST_RUN} state_t;

  state_t      state;
  logic [15:0] align_cnt;
  logic [7:0]  seq;
  logic [56:0] acc;
  logic [4:0]  count;
  logic        acc_sweep;
  logic        sweep_pending;

  logic        capture;
  logic        flush;
  logic        full;
  logic        emit;
  logic [2:0]  sample;
  logic [56:0] base_acc, new_acc, frame_samples;
  logic [4:0]  base_count, new_count, frame_count;
  logic        base_sweep, new_sweep, frame_sweep;

  assign capture = sample_valid & enable;
  assign sample  = {cmp_s21, cmp_s11, cmp_ref};
  assign flush   = (count != 5'd0) & (~enable | sweep_start);

  // A flush empties the accumulator first, so a sample taken in the same
  // cycle lands at index 0 of the following frame.
  always_comb begin
    base_acc   = flush ? '0 : acc;
    base_count = flush ? 5'd0 : count;
    base_sweep = flush ? 1'b0 : acc_sweep;
    new_acc    = base_acc;
    new_count  = base_count;
    new_sweep  = base_sweep;
    if (capture) begin
      for (int k = 0; k < SAMPLES_PER_FRAME; k++) begin
        if (base_count == 5'(k)) new_acc[3*k +: 3] = sample;
      end
      new_count = base_count + 5'd1;
      if (base_count == 5'd0) new_sweep = sweep_pending | sweep_start;
    end
    full          = capture & (new_count == FULL_COUNT);
    emit          = flush | full;
    frame_samples = flush ? acc : new_acc;
    frame_count   = flush ? count : new_count;
    frame_sweep   = flush ? acc_sweep : new_sweep;
  end

  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state         <= ST_ALIGN;
      align_cnt     <= '0;
      seq           <= '0;
      acc           <= '0;
      count         <= '0;
      acc_sweep     <= 1'b0;
      sweep_pending <= 1'b0;
      GTH_DATA      <= ALIGN_WORD;
      frame_valid   <= 1'b0;
      align_done    <= 1'b0;
      triger        <= 1'b0;
    end else if (realign) begin
      state         <= ST_ALIGN;
      align_cnt     <= '0;
      seq           <= '0;
      acc           <= '0;
      count         <= '0;
      acc_sweep     <= 1'b0;
      sweep_pending <= 1'b0;
      GTH_DATA      <= ALIGN_WORD;
      frame_valid   <= 1'b0;
      align_done    <= 1'b0;
      triger        <= 1'b0;
    end else if (state == ST_ALIGN) begin
      frame_valid <= 1'b0;
      triger      <= 1'b0;
      if (align_cnt == ALIGN_LAST) begin
        state      <= ST_RUN;
        GTH_DATA   <= {8'h5A, seq, 64'h0};
        align_done <= 1'b1;
      end else begin
        align_cnt <= align_cnt + 16'd1;
        GTH_DATA  <= ALIGN_WORD;
      end
    end else begin
      acc           <= full ? '0 : new_acc;
      count         <= full ? 5'd0 : new_count;
      acc_sweep     <= full ? 1'b0 : new_sweep;
      sweep_pending <= capture ? 1'b0 : (sweep_pending | sweep_start);
      align_done    <= 1'b1;
      if (emit) begin
        GTH_DATA    <= {8'hA5, seq, frame_count, frame_sweep, 1'b0, frame_samples};
        frame_valid <= 1'b1;
        triger      <= frame_sweep;
        seq         <= seq + 8'd1;
      end else begin
        GTH_DATA    <= {8'h5A, seq, 64'h0};
        frame_valid <= 1'b0;
        triger      <= 1'b0;
      end
    end
  end
endmodule
